// File: rtl/arb_mux.sv
// Registered N-way multiplexer with explicit-select or round-robin arbitration
// feeding a single-entry valid/ready output register.
module arb_mux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NUM   = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [NUM-1:0]       req,
    input  logic [NUM*WIDTH-1:0] data_in,
    output logic [NUM-1:0]       grant,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel
);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] rr_idx;
    logic             cand_valid;
    logic             can_accept;
    logic             accept;
    logic [WIDTH-1:0] cand_data;

    assign can_accept = !out_valid || out_ready;
    assign accept     = !rst && can_accept && cand_valid;

    // Candidate is a function of request/select state only, never of data_in.
    always_comb begin
        cand_valid = 1'b0;
        cand       = '0;
        rr_idx     = '0;
        if (mode == 1'b0) begin
            if (int'(sel) < int'(NUM) && req[sel]) begin
                cand_valid = 1'b1;
                cand       = sel;
            end
        end else begin
            // Scan ptr+1 .. ptr+NUM so the last winner has lowest priority.
            for (int k = 1; k <= int'(NUM); k++) begin
                rr_idx = SEL_W'((int'(ptr_q) + k) % int'(NUM));
                if (!cand_valid && req[rr_idx]) begin
                    cand_valid = 1'b1;
                    cand       = rr_idx;
                end
            end
        end
    end

    always_comb begin
        grant     = '0;
        cand_data = '0;
        for (int i = 0; i < int'(NUM); i++) begin
            if (cand == SEL_W'(i)) begin
                grant[i]  = accept;
                cand_data = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr_q     <= SEL_W'(NUM - 1);
        end else if (can_accept) begin
            if (cand_valid) begin
                out_valid <= 1'b1;
                out_data  <= cand_data;
                out_sel   <= cand;
                ptr_q     <= cand;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: grants are checked by the stimulus, output beats
// are checked by a monitor against a queue of expected {data, sel}.
module tb_arb_mux;

    localparam int WIDTH = 32;
    localparam int NUM   = 4;
    localparam int SEL_W = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 mode;
    logic [SEL_W-1:0]     sel;
    logic [NUM-1:0]       req;
    logic [NUM*WIDTH-1:0] data_in;
    logic [NUM-1:0]       grant;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_W-1:0]     out_sel;

    logic [WIDTH-1:0]       din [NUM];
    logic [WIDTH+SEL_W-1:0] sb [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        data_in = '0;
        for (int i = 0; i < NUM; i++) data_in[i*WIDTH +: WIDTH] = din[i];
    end

    arb_mux #(.WIDTH(WIDTH), .NUM(NUM), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .req       (req),
        .data_in   (data_in),
        .grant     (grant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every consumed output beat must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", {out_data, out_sel}, '0);
            end else begin
                logic [WIDTH+SEL_W-1:0] e;
                e = sb.pop_front();
                check("out_data", 64'(out_data), 64'(e[WIDTH+SEL_W-1:SEL_W]));
                check("out_sel", 64'(out_sel), 64'(e[SEL_W-1:0]));
            end
        end
    end

    // Inputs are already applied; check grant before the edge, queue the
    // expected beat, then advance to just after the edge.
    task automatic step(input string name, input logic [NUM-1:0] exp_grant);
        @(negedge clk);
        check(name, 64'(grant), 64'(exp_grant));
        for (int i = 0; i < NUM; i++) begin
            if (exp_grant[i]) sb.push_back({din[i], SEL_W'(i)});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NUM; i++) din[i] = WIDTH'(i + 1);
        rst = 1'b1; mode = 1'b1; sel = '0; req = 4'b1111; out_ready = 1'b1;
        #1;

        // Reset for two cycles with requests pending
        step("rst_grant0", 4'b0000);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_sel", 64'(out_sel), 64'd0);
        step("rst_grant1", 4'b0000);
        rst = 1'b0;

        // Round-robin, all requesting
        step("rr_g0", 4'b0001);
        step("rr_g1", 4'b0010);
        step("rr_g2", 4'b0100);
        step("rr_g3", 4'b1000);
        step("rr_g0b", 4'b0001);
        req = 4'b1010;
        step("rr_alt1", 4'b0010);
        step("rr_alt3", 4'b1000);
        step("rr_alt1b", 4'b0010);
        step("rr_alt3b", 4'b1000);

        // Explicit select
        mode = 1'b0; sel = 2'd2; req = 4'b0100; din[2] = 32'hDEADBEEF;
        step("sel2", 4'b0100);
        check("sel2_valid", 64'(out_valid), 64'd1);
        sel = 2'd3;
        step("sel3_nogrant", 4'b0000);
        check("sel3_drained", 64'(out_valid), 64'd0);
        check("sel3_hold", 64'(out_data), 64'hDEADBEEF);

        // Backpressure: fill with 5, then stall while req toggles
        din[0] = 32'd5; sel = 2'd0; req = 4'b0001;
        step("bp_fill", 4'b0001);
        out_ready = 1'b0; mode = 1'b1;
        for (int c = 0; c < 3; c++) begin
            req = (c == 1) ? 4'b0000 : ((c == 0) ? 4'b1111 : 4'b0101);
            step("bp_stall_grant", 4'b0000);
            check("bp_stall_valid", 64'(out_valid), 64'd1);
            check("bp_stall_data", 64'(out_data), 64'd5);
        end
        out_ready = 1'b1; req = 4'b0010;
        step("bp_release", 4'b0010);
        check("bp_new_data", 64'(out_data), 64'd2);

        // Drain
        req = 4'b0000;
        step("drain_nogrant", 4'b0000);
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_hold", 64'(out_data), 64'd2);

        // Reset while full and stalled
        req = 4'b0100;
        step("mid_fill", 4'b0100);
        out_ready = 1'b0;
        step("mid_stall", 4'b0000);
        rst = 1'b1; req = 4'b1001;
        step("mid_rst_grant", 4'b0000);
        sb.delete();
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        rst = 1'b0; out_ready = 1'b1;
        step("mid_ptr_reset", 4'b0001);
        req = 4'b0000;
        step("final_drain", 4'b0000);
        check("final_valid", 64'(out_valid), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
